// File: rtl/gate_counter_if.sv
// gate_counter_if: gate control inputs and latched BCD result of the frequency-meter counter
interface gate_counter_if #(
  parameter int DIGITS = 4
);
  logic sigIn, enable, clear, latch;
  logic [4*DIGITS-1:0] countOut;
  logic overflowOut, dataValid;
  modport master(output sigIn, enable, clear, latch, input countOut, overflowOut, dataValid);
  modport slave(input sigIn, enable, clear, latch, output countOut, overflowOut, dataValid);
endinterface

// File: rtl/gate_counter.sv
// gate_counter: gated BCD edge counter with synchronized input and latched result
module gate_counter #(
  parameter int DIGITS = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clkSys,
  input logic reset,
  gate_counter_if.slave gc
);
  logic [SYNC_STAGES-1:0] syncReg;
  logic sigPrev, sigEdge, latchPrev, capture, carry, ovf;
  logic [4*DIGITS-1:0] cnt, cntInc;
  assign sigEdge = syncReg[SYNC_STAGES-1] & ~sigPrev;
  assign capture = gc.latch & ~latchPrev;
  // resynchronize sigIn and keep one delayed copy for rising-edge detection
  always_ff @(posedge clkSys)
    if (reset) begin
      syncReg <= '0;
      sigPrev <= 1'b0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], gc.sigIn};
      sigPrev <= syncReg[SYNC_STAGES-1];
    end
  // BCD increment of cnt, carry ripples up from the units digit; final carry marks a wrap
  always_comb begin
    carry = 1'b1;
    cntInc = cnt;
    for (int i = 0; i < DIGITS; i++) begin
      cntInc[4*i +: 4] = carry ? ((cnt[4*i +: 4] == 4'd9) ? 4'd0 : cnt[4*i +: 4] + 4'd1) : cnt[4*i +: 4];
      carry = carry & (cnt[4*i +: 4] == 4'd9);
    end
  end
  // counter: clear beats counting, wrap from all nines sets the sticky overflow
  always_ff @(posedge clkSys)
    if (reset || !gc.clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (gc.enable && sigEdge) begin
      cnt <= cntInc;
      ovf <= ovf | carry;
    end
  // capture pre-update cnt/ovf on the rising edge of latch; latchPrev resets high so a held latch stays quiet
  always_ff @(posedge clkSys)
    if (reset) begin
      latchPrev <= 1'b1;
      gc.countOut <= '0;
      gc.overflowOut <= 1'b0;
      gc.dataValid <= 1'b0;
    end else begin
      latchPrev <= gc.latch;
      gc.dataValid <= capture;
      if (capture) begin
        gc.countOut <= cnt;
        gc.overflowOut <= ovf;
      end
    end
endmodule

// File: tb/tb_gate_counter.sv
// tb_gate_counter: randomized self-checking bench for gate_counter against a decimal pulse-count model
module tb_gate_counter;
  localparam int DIGITS = 4;
  localparam int MODULUS = 10000;
  logic clkSys = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int modelTotal = 0;
  gate_counter_if #(.DIGITS(DIGITS)) gif();
  gate_counter #(.DIGITS(DIGITS), .SYNC_STAGES(2)) dut(.clkSys(clkSys), .reset(reset), .gc(gif));
  always #5 clkSys = ~clkSys;

  function automatic logic [4*DIGITS-1:0] expBcd(int n);
    int v;
    logic [4*DIGITS-1:0] r;
    v = n % MODULUS;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic pulses(int n, int hi, int lo, bit rnd);
    for (int p = 0; p < n; p++) begin
      gif.sigIn = 1'b1;
      repeat (rnd ? int'($urandom_range(5, 2)) : hi) @(negedge clkSys);
      gif.sigIn = 1'b0;
      repeat (rnd ? int'($urandom_range(5, 2)) : lo) @(negedge clkSys);
    end
    repeat (4) @(negedge clkSys);
  endtask

  task automatic doClear;
    gif.clear = 1'b0;
    @(negedge clkSys);
    gif.clear = 1'b1;
    @(negedge clkSys);
    modelTotal = 0;
  endtask

  task automatic captureObs(output logic [4*DIGITS-1:0] val, output logic ovfO, output logic dvOk);
    logic dvPre;
    dvPre = gif.dataValid;
    gif.latch = 1'b1;
    @(posedge clkSys); #1;
    val = gif.countOut;
    ovfO = gif.overflowOut;
    dvOk = (dvPre === 1'b0) && (gif.dataValid === 1'b1);
    @(posedge clkSys); #1;
    dvOk = dvOk && (gif.dataValid === 1'b0);
    @(negedge clkSys);
    gif.latch = 1'b0;
    @(negedge clkSys);
  endtask

  task automatic test_reset;
    logic [4*DIGITS-1:0] v;
    logic o, ok;
    bit pulsed = 0;
    reset = 1'b1;
    gif.latch = 1'b1;
    gif.enable = 1'b0;
    gif.clear = 1'b1;
    gif.sigIn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clkSys); #1;
      if (gif.dataValid === 1'b1) pulsed = 1;
      @(negedge clkSys);
      gif.sigIn = ~gif.sigIn;
    end
    tests++; if (gif.countOut !== '0) begin fails++; $display("FAIL reset_countOut: got %h expected 0", gif.countOut); end
    tests++; if (gif.overflowOut !== 1'b0) begin fails++; $display("FAIL reset_overflowOut: got %b expected 0", gif.overflowOut); end
    reset = 1'b0;
    repeat (4) begin
      @(posedge clkSys); #1;
      if (gif.dataValid !== 1'b0) pulsed = 1;
    end
    tests++; if (pulsed) begin fails++; $display("FAIL reset_no_dataValid: got pulse expected none"); end
    @(negedge clkSys);
    gif.latch = 1'b0;
    gif.sigIn = 1'b0;
    repeat (4) @(negedge clkSys);
    captureObs(v, o, ok);
    tests++; if (v !== '0) begin fails++; $display("FAIL reset_cnt: got %h expected 0", v); end
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", o); end
    tests++; if (!ok) begin fails++; $display("FAIL reset_capture_dv: got bad pulse expected one cycle"); end
  endtask

  task automatic test_basic_count;
    logic [4*DIGITS-1:0] v;
    logic o, ok;
    doClear();
    gif.enable = 1'b1;
    pulses(37, 3, 3, 0);
    gif.enable = 1'b0;
    modelTotal += 37;
    captureObs(v, o, ok);
    tests++; if (v !== expBcd(modelTotal)) begin fails++; $display("FAIL basic_count: got %h expected %h", v, expBcd(modelTotal)); end
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b expected 0", o); end
    tests++; if (!ok) begin fails++; $display("FAIL basic_dv: got bad pulse expected one cycle"); end
  endtask

  task automatic test_random;
    logic [4*DIGITS-1:0] v;
    logic o, ok;
    int n;
    bit en;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(3, 0) == 0) doClear();
      n = int'($urandom_range(40, 1));
      en = 1'($urandom_range(1, 0));
      gif.enable = en;
      pulses(n, 0, 0, 1);
      gif.enable = 1'b0;
      if (en) modelTotal += n;
      captureObs(v, o, ok);
      tests++; if (v !== expBcd(modelTotal)) begin fails++; $display("FAIL random_count[%0d]: got %h expected %h", it, v, expBcd(modelTotal)); end
      tests++; if (o !== (modelTotal >= MODULUS) || !ok) begin fails++; $display("FAIL random_ovf_dv[%0d]: got ovf=%b dv_ok=%b expected ovf=%b dv_ok=1", it, o, ok, modelTotal >= MODULUS); end
    end
  endtask

  task automatic test_wrap;
    logic [4*DIGITS-1:0] v;
    logic o, ok;
    doClear();
    gif.enable = 1'b1;
    pulses(MODULUS - 1, 2, 2, 0);
    modelTotal += MODULUS - 1;
    captureObs(v, o, ok);
    tests++; if (v !== expBcd(modelTotal)) begin fails++; $display("FAIL wrap_9999: got %h expected %h", v, expBcd(modelTotal)); end
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL wrap_9999_ovf: got %b expected 0", o); end
    pulses(1, 2, 2, 0);
    gif.enable = 1'b0;
    modelTotal += 1;
    captureObs(v, o, ok);
    tests++; if (v !== expBcd(modelTotal)) begin fails++; $display("FAIL wrap_0000: got %h expected %h", v, expBcd(modelTotal)); end
    tests++; if (o !== 1'b1) begin fails++; $display("FAIL wrap_ovf: got %b expected 1", o); end
    tests++; if (!ok) begin fails++; $display("FAIL wrap_dv: got bad pulse expected one cycle"); end
    doClear();
    captureObs(v, o, ok);
    tests++; if (v !== '0 || o !== 1'b0) begin fails++; $display("FAIL wrap_clear: got %h ovf=%b expected 0000 ovf=0", v, o); end
  endtask

  task automatic test_gate_closed;
    logic [4*DIGITS-1:0] v;
    logic o, ok;
    doClear();
    gif.enable = 1'b1;
    pulses(9, 0, 0, 1);
    gif.enable = 1'b0;
    modelTotal += 9;
    pulses(20, 2, 3, 0);
    captureObs(v, o, ok);
    tests++; if (v !== expBcd(modelTotal)) begin fails++; $display("FAIL gate_closed: got %h expected %h", v, expBcd(modelTotal)); end
    tests++; if (!ok) begin fails++; $display("FAIL gate_closed_dv: got bad pulse expected one cycle"); end
  endtask

  task automatic test_simultaneous;
    logic [4*DIGITS-1:0] v;
    logic o, ok;
    doClear();
    gif.enable = 1'b1;
    pulses(12, 0, 0, 1);
    gif.enable = 1'b0;
    modelTotal += 12;
    gif.clear = 1'b0;
    gif.latch = 1'b1;
    @(posedge clkSys); #1;
    tests++; if (gif.countOut !== expBcd(modelTotal) || gif.dataValid !== 1'b1) begin fails++; $display("FAIL clear_capture: got %h dv=%b expected %h dv=1", gif.countOut, gif.dataValid, expBcd(modelTotal)); end
    @(negedge clkSys);
    gif.clear = 1'b1;
    gif.latch = 1'b0;
    @(negedge clkSys);
    modelTotal = 0;
    captureObs(v, o, ok);
    tests++; if (v !== '0 || o !== 1'b0) begin fails++; $display("FAIL clear_after_capture: got %h ovf=%b expected 0000 ovf=0", v, o); end
    gif.enable = 1'b1;
    pulses(7, 0, 0, 1);
    modelTotal += 7;
    gif.sigIn = 1'b1;
    @(negedge clkSys);
    @(negedge clkSys);
    gif.latch = 1'b1;
    @(posedge clkSys); #1;
    tests++; if (gif.countOut !== expBcd(modelTotal) || gif.dataValid !== 1'b1) begin fails++; $display("FAIL edge_capture_pre: got %h dv=%b expected %h dv=1", gif.countOut, gif.dataValid, expBcd(modelTotal)); end
    @(negedge clkSys);
    gif.sigIn = 1'b0;
    repeat (4) @(negedge clkSys);
    gif.latch = 1'b0;
    gif.enable = 1'b0;
    @(negedge clkSys);
    modelTotal += 1;
    captureObs(v, o, ok);
    tests++; if (v !== expBcd(modelTotal)) begin fails++; $display("FAIL edge_capture_post: got %h expected %h", v, expBcd(modelTotal)); end
  endtask

  task automatic test_reset_mid;
    logic [4*DIGITS-1:0] v;
    logic o, ok;
    doClear();
    gif.enable = 1'b1;
    pulses(5, 0, 0, 1);
    reset = 1'b1;
    @(negedge clkSys);
    @(negedge clkSys);
    reset = 1'b0;
    modelTotal = 0;
    tests++; if (gif.countOut !== '0) begin fails++; $display("FAIL reset_mid_countOut: got %h expected 0", gif.countOut); end
    pulses(3, 0, 0, 1);
    gif.enable = 1'b0;
    modelTotal += 3;
    captureObs(v, o, ok);
    tests++; if (v !== expBcd(modelTotal) || o !== 1'b0) begin fails++; $display("FAIL reset_mid_count: got %h ovf=%b expected %h ovf=0", v, o, expBcd(modelTotal)); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_random();
    test_simultaneous();
    test_wrap();
    test_gate_closed();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
